// File: rtl/uart_apb_pkg.sv
// Shared types and constants for the UART APB initiator.
package uart_apb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  // UART register block address map
  localparam logic [31:0] UART_TXD  = 32'h0000_0000;
  localparam logic [31:0] UART_RXD  = 32'h0000_0001;
  localparam logic [31:0] UART_STAT = 32'h0000_0005;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/uart_apb_wait_timer.sv
// ACCESS-phase wait-state counter. Only instantiated when APB_TIMEOUT_EN is
// defined. o_expired flags that the current wait cycle is the LIMIT-th one.
module uart_apb_wait_timer #(
  parameter int LIMIT = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expired
);

  localparam logic [7:0] LIMIT_M1 = 8'(LIMIT - 1);

  logic [7:0] r_count;

  // Count wait cycles, saturating at 255; cleared at the start of each transfer
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= 8'd0;
    end else if (i_clr) begin
      r_count <= 8'd0;
    end else if (i_inc && (r_count != 8'hFF)) begin
      r_count <= r_count + 8'd1;
    end else begin
      r_count <= r_count;
    end
  end

  // A wait in this cycle would bring the count up to LIMIT
  assign o_expired = (r_count >= LIMIT_M1);

endmodule

// File: rtl/uart_apb_master.sv
// APB initiator for the UART register block: turns a valid/ready command
// stream into APB SETUP/ACCESS transfers, one in flight, and returns read data
// and error status on a valid/ready response stream.
// Optional feature: define APB_TIMEOUT_EN to abort ACCESS after
// TIMEOUT_CYCLES wait states with an error response.
module uart_apb_master
  import uart_apb_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              pClk,
  input  logic              pReset,
  input  logic              cmdValid,
  output logic              cmdReady,
  input  logic              cmdWrite,
  input  logic [ADDR_W-1:0] cmdAddr,
  input  logic [DATA_W-1:0] cmdWdata,
  output logic              rspValid,
  input  logic              rspReady,
  output logic [DATA_W-1:0] rspRdata,
  output logic              rspErr,
  output logic              pSel,
  output logic              pEnable,
  output logic              pWrite,
  output logic [ADDR_W-1:0] pAddr,
  output logic [DATA_W-1:0] pWdata,
  input  logic              pReady,
  input  logic [DATA_W-1:0] pReadData,
  input  logic              pSlvErr
);

  apb_state_e        r_state;
  apb_state_e        w_state_nxt;
  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic [DATA_W-1:0] r_rsp_rdata;

  logic w_accept;
  logic w_consume;
  logic w_done;
  logic w_timeout;
  logic w_finish;

  // A new command may only be taken when idle and the response slot frees up
  assign cmdReady  = (r_state == IDLE) && (!r_rsp_valid || rspReady);
  assign w_accept  = cmdValid && cmdReady;
  assign w_consume = r_rsp_valid && rspReady;
  assign w_done    = (r_state == ACCESS) && pReady;

`ifdef APB_TIMEOUT_EN
  logic w_tmr_clr;
  logic w_tmr_inc;
  logic w_expired;

  assign w_tmr_clr = (r_state == SETUP);
  assign w_tmr_inc = (r_state == ACCESS) && !pReady;

  uart_apb_wait_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .i_clk     (pClk),
    .i_rst_n   (pReset),
    .i_clr     (w_tmr_clr),
    .i_inc     (w_tmr_inc),
    .o_expired (w_expired)
  );

  // Normal completion (pReady=1) always beats the timeout
  assign w_timeout = (r_state == ACCESS) && !pReady && w_expired;
`else
  assign w_timeout = 1'b0;
`endif

  assign w_finish = w_done || w_timeout;

  // FSM state register
  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = SETUP;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SETUP: begin
        w_state_nxt = ACCESS;
      end
      ACCESS: begin
        if (w_finish) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = ACCESS;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // APB request signals: address/direction/data change only on accept
  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= {ADDR_W{1'b0}};
      r_pwdata  <= {DATA_W{1'b0}};
    end else if (w_accept) begin
      r_psel    <= 1'b1;
      r_penable <= 1'b0;
      r_pwrite  <= cmdWrite;
      r_paddr   <= cmdAddr;
      r_pwdata  <= cmdWrite ? cmdWdata : {DATA_W{1'b0}};
    end else if (r_state == SETUP) begin
      r_penable <= 1'b1;
    end else if (w_finish) begin
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
    end
  end

  // Response slot: loaded at completion, held until consumed
  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= {DATA_W{1'b0}};
    end else if (w_finish) begin
      r_rsp_valid <= 1'b1;
      r_rsp_err   <= w_done ? pSlvErr : 1'b1;
      r_rsp_rdata <= (w_done && !r_pwrite && !pSlvErr) ? pReadData : {DATA_W{1'b0}};
    end else if (w_consume) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign pSel     = r_psel;
  assign pEnable  = r_penable;
  assign pWrite   = r_pwrite;
  assign pAddr    = r_paddr;
  assign pWdata   = r_pwdata;
  assign rspValid = r_rsp_valid;
  assign rspErr   = r_rsp_err;
  assign rspRdata = r_rsp_rdata;

endmodule
